// File: rtl/right_shift_unit_pkg.sv
// Shared encodings and default sizes for the iterative right shifter.
// Rotate decode is present only when RIGHT_SHIFT_ROTATE_EN is defined.
package right_shift_unit_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROTR = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/right_shift_unit_if.sv
// Request/result bundle between the multi-cycle controller (master)
// and the right shift unit (slave).
interface right_shift_unit_if
  import right_shift_unit_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
);

  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result
  );

endinterface

// File: rtl/right_shift_unit_step.sv
// Combinational one-position right step; the incoming MSB is chosen by op.
// Rotate fill (bit 0 wraps to the MSB) exists only with RIGHT_SHIFT_ROTATE_EN.
module right_shift_step
  import right_shift_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  output logic [WIDTH-1:0] shifted
);

  logic fill;

  // Reserved and (without rotate support) ROTR encodings fall back to SRL.
  always_comb begin
    fill = 1'b0;
    case (op)
      OP_SRA:  fill = value[WIDTH-1];
`ifdef RIGHT_SHIFT_ROTATE_EN
      OP_ROTR: fill = value[0];
`endif
      default: fill = 1'b0;
    endcase
  end

  assign shifted = WIDTH'({fill, value} >> 1);

endmodule

// File: rtl/right_shift_unit.sv
// Iterative right shifter (SRL/SRA, optional ROTR under RIGHT_SHIFT_ROTATE_EN),
// one bit position per clock; done pulses for one cycle when result is valid.
module right_shift_unit
  import right_shift_unit_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic              clk,
  input  logic              rst,
  right_shift_unit_if.slave bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_value;

  right_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value   (sreg_q),
    .op      (op_q),
    .shifted (step_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= OP_SRL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      done_q   <= done_d;
    end
  end

  // The count is checked before shifting, so shamt=0 finishes one edge after start.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.data_in;
          cnt_d   = bus.shamt;
          op_d    = op_e'(bus.op);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          result_d = sreg_q;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          sreg_d = step_value;
          cnt_d  = cnt_q - SHAMT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy   = (state_q != ST_IDLE);
    bus.done   = done_q;
    bus.result = result_q;
  end

endmodule

// File: tb/tb_right_shift_unit.sv
// Directed self-checking bench for right_shift_unit; expected values are hand-computed.
// ROTR expectation follows RIGHT_SHIFT_ROTATE_EN.
module tb_right_shift_unit;
  import right_shift_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  right_shift_unit_if bus_if ();

  right_shift_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after the start edge E0.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] data,
                                input logic [4:0] sh);
    bus_if.op      = op;
    bus_if.data_in = data;
    bus_if.shamt   = sh;
    bus_if.start   = 1'b1;
    next_cycle();
    bus_if.start   = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [4:0] sh, input logic [31:0] expected);
    int cyc;
    cyc = 0;
    apply_stimulus(op, data, sh);
    while (bus_if.done !== 1'b1 && cyc < 64) begin
      next_cycle();
      cyc++;
    end
    check_output({tag, " latency"}, 32'(cyc), 32'(sh) + 32'd1);
    check_output({tag, " result"}, bus_if.result, expected);
    check_bit({tag, " busy_in_done"}, bus_if.busy, 1'b1);
    next_cycle();
    check_bit({tag, " done_fall"}, bus_if.done, 1'b0);
    check_bit({tag, " busy_fall"}, bus_if.busy, 1'b0);
    check_output({tag, " result_hold"}, bus_if.result, expected);
  endtask

  initial begin
    int done_count;
    logic [31:0] rotr_expected;

    rst            = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.op      = 2'b00;
    bus_if.data_in = '0;
    bus_if.shamt   = '0;
    repeat (3) next_cycle();
    check_bit("reset busy", bus_if.busy, 1'b0);
    check_bit("reset done", bus_if.done, 1'b0);
    check_output("reset result", bus_if.result, 32'h0);
    rst = 1'b0;
    next_cycle();

    $display("[TB] SRL 0x80000000 >> 4 with cycle-by-cycle busy/done");
    apply_stimulus(OP_SRL, 32'h8000_0000, 5'd4);
    check_bit("srl busy E0", bus_if.busy, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      check_bit($sformatf("srl done E%0d", k), bus_if.done, (k == 5));
      check_bit($sformatf("srl busy E%0d", k), bus_if.busy, (k <= 5));
      if (k == 5) check_output("srl result", bus_if.result, 32'h0800_0000);
    end

    $display("[TB] SRA and zero shift");
    run_op("sra neg", OP_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000);
    run_op("sra pos", OP_SRA, 32'h7FFF_FFF0, 5'd4, 32'h07FF_FFFF);
    run_op("sra sh0", OP_SRA, 32'h1234_5678, 5'd0, 32'h1234_5678);
    run_op("rsvd op", OP_RSVD, 32'h8000_0000, 5'd1, 32'h4000_0000);

    $display("[TB] SRA by 31 with ignored starts");
    apply_stimulus(OP_SRA, 32'hFFFF_FFFF, 5'd31);
    for (int k = 1; k <= 34; k++) begin
      next_cycle();
      if (k == 9) begin
        bus_if.start   = 1'b1;
        bus_if.data_in = 32'h0000_0001;
        bus_if.op      = OP_SRL;
        bus_if.shamt   = 5'd0;
      end
      if (k == 10) bus_if.start = 1'b0;
      if (k == 31) check_bit("sra31 done early", bus_if.done, 1'b0);
      if (k == 32) begin
        check_bit("sra31 done E32", bus_if.done, 1'b1);
        check_output("sra31 result", bus_if.result, 32'hFFFF_FFFF);
        bus_if.start = 1'b1;
      end
      if (k == 33) begin
        bus_if.start = 1'b0;
        check_bit("sra31 done fall", bus_if.done, 1'b0);
        check_bit("start in done ignored", bus_if.busy, 1'b0);
      end
      if (k == 34) check_output("sra31 result hold", bus_if.result, 32'hFFFF_FFFF);
    end
    run_op("b2b srl", OP_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F);

    $display("[TB] reset mid-operation");
    apply_stimulus(OP_SRL, 32'hAAAA_5555, 5'd10);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_bit("abort busy", bus_if.busy, 1'b0);
    check_bit("abort done", bus_if.done, 1'b0);
    check_output("abort result", bus_if.result, 32'h0);
    done_count = 0;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      if (bus_if.done === 1'b1) done_count++;
    end
    check_output("abort no done", 32'(done_count), 32'd0);

    $display("[TB] op=10 decode");
`ifdef RIGHT_SHIFT_ROTATE_EN
    rotr_expected = 32'h8000_0000;
`else
    rotr_expected = 32'h0000_0000;
`endif
    run_op("op10", OP_ROTR, 32'h0000_0001, 5'd1, rotr_expected);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
